branch_seq_ctrl: RTL and testbench

Multicycle instruction sequencer for the single-issue processor. It owns the program counter, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives the branch comparator. It presents `br_op` during EXEC, samples the comparator's `is_branch` result, and selects the next PC. It sits between instruction memory, the decoder, the data-memory port and the register-file write enable.

---
 rtl/branch_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: multicycle instruction sequencer. It owns the PC, walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the branch comparator.
// Optional feature macro: BR_STATS_EN adds saturating taken/not-taken branch counters.
//
// Handshakes: imem_req/mem_req are held high for as long as the FSM sits in
// FETCH/MEM. The matching ack completes the request on the rising edge where
// both are high. An ack seen while the request is low is ignored.
module branch_seq_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            dec_is_br,
  input  logic [2:0]      dec_br_op,
  input  logic [PC_W-1:0] dec_br_target,
  input  logic            dec_is_mem,
  input  logic            dec_is_halt,
  output logic [2:0]      br_op,
  input  logic            is_branch,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            reg_we,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
`ifdef BR_STATS_EN
  output logic [15:0]     br_taken_cnt,
  output logic [15:0]     br_ntaken_cnt,
`endif
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Decoded fields captured in DECODE so the decoder inputs may change afterwards.
  logic            is_br_q, is_mem_q, is_halt_q;
  logic [2:0]      br_op_q;
  logic [PC_W-1:0] target_q;

  logic            br_fire;   // EXEC cycle of a (non-halt) branch
  logic            br_taken;  // comparator says taken and opcode is a real branch

  assign br_fire  = (state_q == S_EXEC) && is_br_q && !is_halt_q;
  // Opcodes with the top bit set are never taken, whatever the comparator says.
  assign br_taken = br_fire && is_branch && !br_op_q[2];

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Capture the decoder outputs during DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_br_q   <= 1'b0;
      is_mem_q  <= 1'b0;
      is_halt_q <= 1'b0;
      br_op_q   <= 3'b111;
      target_q  <= '0;
    end else if (state_q == S_DECODE) begin
      is_br_q   <= dec_is_br;
      is_mem_q  <= dec_is_mem;
      is_halt_q <= dec_is_halt;
      br_op_q   <= dec_br_op;
      target_q  <= dec_br_target;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt_q) begin
          state_d = S_HALT;
        end else if (is_br_q) begin
          state_d = S_FETCH;
          // Branch targets are forced word-aligned by clearing the low two bits.
          pc_d    = br_taken ? (target_q & ~PC_W'(3)) : pc_q + PC_W'(4);
        end else if (is_mem_q) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM:    if (mem_ack) state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(4);
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore-style outputs decoded from the current state.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    mem_req   = (state_q == S_MEM);
    reg_we    = (state_q == S_WB);
    halted    = (state_q == S_HALT);
    br_op     = br_fire ? br_op_q : 3'b111;
    imem_addr = pc_q;
    pc        = pc_q;
    state     = state_q;
  end

`ifdef BR_STATS_EN
  logic [15:0] br_taken_cnt_q, br_ntaken_cnt_q;

  // Saturating branch outcome counters, one increment per executed branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt_q  <= '0;
      br_ntaken_cnt_q <= '0;
    end else if (br_fire) begin
      if (br_taken) begin
        if (br_taken_cnt_q != 16'hFFFF) br_taken_cnt_q <= br_taken_cnt_q + 16'd1;
      end else begin
        if (br_ntaken_cnt_q != 16'hFFFF) br_ntaken_cnt_q <= br_ntaken_cnt_q + 16'd1;
      end
    end
  end

  assign br_taken_cnt  = br_taken_cnt_q;
  assign br_ntaken_cnt = br_ntaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: directed bench for branch_seq_ctrl with a per-instruction
// trace model, a per-cycle compare process and hand-computed literal checks.
module tb_branch_seq_ctrl;

  localparam int          PC_W   = 32;
  localparam logic [31:0] RST_PC = 32'h100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack, mem_req, mem_ack, reg_we, halted, is_branch;
  logic [31:0] imem_addr, pc, dec_br_target;
  logic        dec_is_br, dec_is_mem, dec_is_halt;
  logic [2:0]  dec_br_op, br_op, state;
`ifdef BR_STATS_EN
  logic [15:0] br_taken_cnt, br_ntaken_cnt;
`endif

  branch_seq_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .dec_is_br(dec_is_br), .dec_br_op(dec_br_op), .dec_br_target(dec_br_target),
    .dec_is_mem(dec_is_mem), .dec_is_halt(dec_is_halt),
    .br_op(br_op), .is_branch(is_branch),
    .mem_req(mem_req), .mem_ack(mem_ack), .reg_we(reg_we),
    .pc(pc), .state(state),
`ifdef BR_STATS_EN
    .br_taken_cnt(br_taken_cnt), .br_ntaken_cnt(br_ntaken_cnt),
`endif
    .halted(halted)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {state[2:0], pc[31:0], imem_req, mem_req, reg_we, br_op[2:0], halted}
  logic [41:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mpc;        // model PC
  int          cyc = 0;
  int          we_cnt = 0;
  int          mreq_cnt = 0;

  function automatic logic [41:0] pack(input logic [2:0] st, input logic [31:0] p,
                                       input logic ir, input logic mr, input logic we,
                                       input logic [2:0] bo, input logic h);
    return {st, p, ir, mr, we, bo, h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reg_we === 1'b1) we_cnt++;
    if (mem_req === 1'b1) mreq_cnt++;
  end

  // Per-cycle compare against the model trace.
  always @(negedge clk) begin
    logic [41:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack(state, pc, imem_req, mem_req, reg_we, br_op, halted);
      total++;
      if (a !== e || imem_addr !== e[38:7]) begin
        bad++;
        $display("FAIL trace: got st=%0d pc=%h addr=%h ireq=%b mreq=%b we=%b bop=%b h=%b expected st=%0d pc=%h ireq=%b mreq=%b we=%b bop=%b h=%b (t=%0t)",
                 state, pc, imem_addr, imem_req, mem_req, reg_we, br_op, halted,
                 e[41:39], e[38:7], e[6], e[5], e[4], e[3:1], e[0], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_random();
    dec_is_br     = 1'($urandom);
    dec_br_op     = 3'($urandom);
    dec_br_target = $urandom;
    dec_is_mem    = 1'($urandom);
    dec_is_halt   = 1'($urandom);
    is_branch     = 1'($urandom);
  endtask

  // Asserts reset, checks reset values, releases it and steps through IDLE.
  // Returns 1 time unit after the edge that enters FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; mem_ack = 1'b0;
    drive_random();
    exp_q.delete();
    @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_br_op", br_op, 3'b111);
    check("rst_outs", {imem_req, mem_req, reg_we, halted}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mpc = RST_PC;
    // Acks during IDLE must be ignored.
    imem_ack = 1'b1; mem_ack = 1'b1;
    exp_q.push_back(pack(3'd0, mpc, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0));
    @(posedge clk); #1;
  endtask

  // Runs one instruction. fw/mw are wait cycles before imem_ack/mem_ack, stray drives
  // the other ack high where it must be ignored, max_cyc truncates the instruction.
  task automatic run_instr(input bit is_br, input logic [2:0] op, input logic [31:0] tgt,
                           input bit is_mem, input bit is_halt, input bit br_res,
                           input int fw, input int mw, input int max_cyc, input bit stray);
    int          ph[$];
    bit          ak[$];
    logic [31:0] npc;
    logic [2:0]  bexp;
    bit          taken;
    for (int i = 0; i <= fw; i++) begin ph.push_back(1); ak.push_back(i == fw); end
    ph.push_back(2); ak.push_back(1'b0);
    ph.push_back(3); ak.push_back(1'b0);
    taken = is_br && br_res && (op <= 3'd3);
    npc   = mpc + 32'd4;
    if (!is_halt && is_br) begin
      if (taken) npc = tgt & 32'hFFFF_FFFC;
    end else if (!is_halt) begin
      if (is_mem) for (int i = 0; i <= mw; i++) begin ph.push_back(4); ak.push_back(i == mw); end
      ph.push_back(5); ak.push_back(1'b0);
    end
    bexp = (is_br && !is_halt) ? op : 3'b111;
    for (int k = 0; k < ph.size() && k < max_cyc; k++)
      exp_q.push_back(pack(3'(ph[k]), mpc, ph[k] == 1, ph[k] == 4, ph[k] == 5,
                           (ph[k] == 3) ? bexp : 3'b111, 1'b0));
    for (int k = 0; k < ph.size() && k < max_cyc; k++) begin
      imem_ack = (ph[k] == 1) ? ak[k] : stray;
      mem_ack  = (ph[k] == 4) ? ak[k] : stray;
      drive_random();
      if (ph[k] == 2) begin
        dec_is_br = is_br; dec_br_op = op; dec_br_target = tgt;
        dec_is_mem = is_mem; dec_is_halt = is_halt;
      end
      if (ph[k] == 3) is_branch = br_res;
      @(posedge clk); #1;
    end
    if (ph.size() <= max_cyc && !is_halt) mpc = npc;
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pack(3'd6, mpc, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1));
      imem_ack = 1'($urandom); mem_ack = 1'($urandom);
      drive_random();
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int c0, w0, m0;

  initial begin
    imem_ack = 1'b0; mem_ack = 1'b0;
    dec_is_br = 1'b0; dec_br_op = 3'd0; dec_br_target = '0;
    dec_is_mem = 1'b0; dec_is_halt = 1'b0; is_branch = 1'b0;
    do_reset();

    // ALU instruction from RESET_PC: 4 cycles, one reg_we, next fetch at 0x104.
    c0 = cyc; w0 = we_cnt;
    run_instr(0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 99, 1);
    check("alu_cycles", cyc - c0, 4);
    check("alu_we", we_cnt - w0, 1);
    check("alu_next_addr", imem_addr, 32'h104);
    check("alu_next_state", state, 3'd1);

    // BZ taken to 0x203: 3 cycles, no reg_we, next fetch 0x200.
    c0 = cyc; w0 = we_cnt;
    run_instr(1, 3'b011, 32'h203, 0, 0, 1, 0, 0, 99, 0);
    check("bz_cycles", cyc - c0, 3);
    check("bz_we", we_cnt - w0, 0);
    check("bz_target", imem_addr, 32'h200);

    // BR taken to the top word, then BMI not taken wraps to 0.
    run_instr(1, 3'b000, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 99, 0);
    check("br_top", pc, 32'hFFFF_FFFC);
    run_instr(1, 3'b001, 32'h1234, 0, 0, 0, 0, 0, 99, 0);
    check("bmi_wrap", pc, 32'h0);

    // Opcode 110 with comparator forced taken: not taken.
    run_instr(1, 3'b110, 32'h800, 0, 0, 1, 0, 0, 99, 0);
    check("op110_ntaken", pc, 32'h4);

    // BPL taken with two fetch wait cycles.
    c0 = cyc;
    run_instr(1, 3'b010, 32'h40, 0, 0, 1, 2, 0, 99, 1);
    check("bpl_cycles", cyc - c0, 5);
    check("bpl_target", pc, 32'h40);
`ifdef BR_STATS_EN
    check("stat_taken", br_taken_cnt, 16'd3);
    check("stat_ntaken", br_ntaken_cnt, 16'd2);
`endif

    // Memory instruction, mem_ack after 3 wait cycles: mem_req 4 cycles, 8 total.
    c0 = cyc; w0 = we_cnt; m0 = mreq_cnt;
    run_instr(0, 3'd0, 32'h0, 1, 0, 0, 0, 3, 99, 0);
    check("mem_cycles", cyc - c0, 8);
    check("mem_req_cycles", mreq_cnt - m0, 4);
    check("mem_we", we_cnt - w0, 1);
    check("mem_next", pc, 32'h44);

    // Branch that is also flagged mem: branch wins, no MEM visit.
    m0 = mreq_cnt;
    run_instr(1, 3'b000, 32'h900, 1, 0, 0, 0, 0, 99, 0);
    check("brmem_nomem", mreq_cnt - m0, 0);
    check("brmem_pc", pc, 32'h48);

    // ALU with a fetch wait and stray acks.
    run_instr(0, 3'd0, 32'h0, 0, 0, 0, 1, 0, 99, 1);
    check("alu2_pc", pc, 32'h4C);

`ifdef BR_STATS_EN
    // Saturation of the taken counter.
    force dut.br_taken_cnt_q = 16'hFFFF;
    #1 release dut.br_taken_cnt_q;
    run_instr(1, 3'b011, 32'h80, 0, 0, 1, 0, 0, 99, 0);
    check("stat_sat", br_taken_cnt, 16'hFFFF);
    check("stat_ntaken2", br_ntaken_cnt, 16'd3);
`endif

    // Reset asserted during a MEM wait: everything drops immediately.
    run_instr(0, 3'd0, 32'h0, 1, 0, 0, 0, 10, 5, 0);
    check("midmem_req_before", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midmem_req", mem_req, 1'b0);
    check("midmem_state", state, 3'd0);
    check("midmem_pc", pc, RST_PC);
    check("midmem_ireq", imem_req, 1'b0);
    do_reset();

    // Halt (also flagged mem): HALT entered, pc frozen for 25 cycles.
    run_instr(0, 3'd0, 32'h0, 1, 1, 0, 0, 0, 99, 0);
    hold_halt(25);
    check("halt_flag", halted, 1'b1);
    check("halt_pc", pc, RST_PC + 32'h0);
    check("halt_state", state, 3'd6);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
